// File: rtl/spi_dac_pkg.sv
// Shared state encoding and default configuration for the SPI DAC writer.
package spi_dac_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SHIFT_H = 3'd2,
    SHIFT_L = 3'd3,
    HOLD    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int          DEF_DW        = 32;
  localparam int          DEF_NCH       = 4;
  localparam int          DEF_CLKDIV    = 1;
  localparam logic [63:0] DEF_INIT_WORD = 64'h0000_0000_0a00_0000;

endpackage

// File: rtl/spi_dac_tick.sv
// Half-period timer: 'last' marks the final clk cycle of a CLKDIV-long phase.
module spi_dac_tick #(
  parameter int CLKDIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic last
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign last = (cnt == 8'(CLKDIV - 1));

endmodule

// File: rtl/spi_dac_writer.sv
// SPI DAC frame writer: MSB-first word to one of NCH active-low syncs.
// Define SPI_DAC_WRITER_INIT_EN to send INIT_WORD to every channel after reset.
module spi_dac_writer
  import spi_dac_pkg::*;
#(
  parameter int          DW        = DEF_DW,
  parameter int          NCH       = DEF_NCH,
  parameter int          CLKDIV    = DEF_CLKDIV,
  parameter logic [63:0] INIT_WORD = DEF_INIT_WORD,
  localparam int         CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [CW-1:0]  ch,
  input  logic [DW-1:0]  data,
  output logic           ready,
  output logic           done,
  output logic           err,
  output logic           din,
  output logic           sclk,
  output logic [NCH-1:0] syn,
  output state_t         dbg_state
);

  localparam int            BW     = $clog2(DW + 1);
  localparam logic [DW-1:0] INIT_W = DW'(INIT_WORD);

  // Handshake: a request is taken on any rising edge where start=1 and
  // ready=1; ready is high only in IDLE, so start is ignored mid-frame.
  state_t          state_q, state_d;
  logic [DW-1:0]   sreg;
  logic [CW-1:0]   ch_q;
  logic [BW-1:0]   bit_cnt;
  logic            err_q;
  logic            tick_last;
  logic            ch_ok, accept, reject;
  logic            init_pend;
  logic [CW-1:0]   init_ch;

`ifdef SPI_DAC_WRITER_INIT_EN
  // One init frame per channel; done stays quiet while these run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_pend <= 1'b1;
      init_ch   <= '0;
    end else if (state_q == DONE && init_pend) begin
      if (init_ch == CW'(NCH - 1)) begin
        init_pend <= 1'b0;
      end else begin
        init_ch <= init_ch + 1'b1;
      end
    end
  end
`else
  assign init_pend = 1'b0;
  assign init_ch   = '0;
`endif

  assign ready  = (state_q == IDLE) && !init_pend;
  assign ch_ok  = (32'(ch) < NCH);
  assign accept = ready && start && ch_ok;
  assign reject = ready && start && !ch_ok;

  spi_dac_tick #(.CLKDIV(CLKDIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (state_d != state_q),
    .last    (tick_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (init_pend || accept) state_d = SETUP;
      SETUP:   if (tick_last) state_d = SHIFT_H;
      SHIFT_H: if (tick_last) state_d = SHIFT_L;
      SHIFT_L: if (tick_last) state_d = (bit_cnt == BW'(DW - 1)) ? HOLD : SHIFT_H;
      HOLD:    if (tick_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg    <= '0;
      ch_q    <= '0;
      bit_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= reject;
      if (state_q == IDLE) begin
        bit_cnt <= '0;
        if (init_pend) begin
          sreg <= INIT_W;
          ch_q <= init_ch;
        end else if (accept) begin
          sreg <= data;
          ch_q <= ch;
        end
      end
      // Next bit is presented only as sclk rises, keeping din steady over the fall.
      if (state_q == SHIFT_L && tick_last) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (state_d == SHIFT_H) sreg <= {sreg[DW-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    sclk = 1'b1;
    din  = 1'b0;
    syn  = '1;
    case (state_q)
      SETUP, SHIFT_H: begin
        din = sreg[DW-1];
        syn = ~(NCH'(1) << ch_q);
      end
      SHIFT_L: begin
        sclk = 1'b0;
        din  = sreg[DW-1];
        syn  = ~(NCH'(1) << ch_q);
      end
      HOLD:    syn = ~(NCH'(1) << ch_q);
      default: ;
    endcase
  end

  assign done      = (state_q == DONE) && !init_pend;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_dac_writer.sv
// Scoreboard bench for spi_dac_writer: random requests, back-to-back and mid-frame reset.
module tb_spi_dac_writer;
  import spi_dac_pkg::*;

  localparam int          DW       = 24;
  localparam int          NCH      = 3;
  localparam int          CLKDIV   = 2;
  localparam int          CW       = 2;
  localparam logic [63:0] INIT_WORD = 64'h0000_0000_0ac3_a5e1;
  localparam logic [DW-1:0] INIT_EXP = 24'hc3a5e1;
  localparam int          LAT      = (2 * DW + 2) * CLKDIV + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [CW-1:0]  ch;
  logic [DW-1:0]  data;
  logic           ready, done, err, din, sclk;
  logic [NCH-1:0] syn;
  state_t         dbg_state;

  spi_dac_writer #(
    .DW(DW), .NCH(NCH), .CLKDIV(CLKDIV), .INIT_WORD(INIT_WORD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ch(ch), .data(data),
    .ready(ready), .done(done), .err(err), .din(din), .sclk(sclk),
    .syn(syn), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic          is_init;
    logic [CW-1:0] ch;
    logic [DW-1:0] data;
    logic [31:0]   acc;
  } exp_t;

  exp_t exp_q[$];
  int   err_exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   hung  = 1'b0;
  logic [NCH-1:0] all1 = '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // driver tasks
  task automatic push_init();
`ifdef SPI_DAC_WRITER_INIT_EN
    exp_t e;
    for (int i = 0; i < NCH; i++) begin
      e = '{is_init: 1'b1, ch: CW'(i), data: INIT_EXP, acc: 32'd0};
      exp_q.push_back(e);
    end
`endif
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 64'(ready), 64'd1);
      hung = 1'b1;
    end
  endtask

  task automatic issue(input logic [CW-1:0] c, input logic [DW-1:0] d);
    exp_t e;
    if (hung) return;
    wait_ready();
    if (hung) return;
    start = 1'b1;
    ch    = c;
    data  = d;
    if (32'(c) < NCH) begin
      e = '{is_init: 1'b0, ch: c, data: d, acc: 32'(cyc + 1)};
      exp_q.push_back(e);
    end else begin
      err_exp_q.push_back(cyc + 1);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // monitor / scoreboard
  bit             in_frame = 1'b0;
  bit             have_end = 1'b0;
  int             last_end = 0;
  int             nbits = 0;
  logic [DW-1:0]  got;
  logic           prev_sclk = 1'b1;
  logic           prev_din = 1'b0;
  exp_t           cur;
  logic [NCH-1:0] cur_syn;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (in_frame) begin
        in_frame = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      have_end  = 1'b0;
      prev_sclk = 1'b1;
      prev_din  = 1'b0;
    end else if (reset === 1'b1) begin
      if (err) begin
        if (err_exp_q.size() > 0 && err_exp_q[0] == cyc) begin
          void'(err_exp_q.pop_front());
          check("err_ready", 64'(ready), 64'd1);
          check("err_syn", 64'(syn), 64'(all1));
        end else begin
          check("err_spurious", 64'(err), 64'd0);
        end
      end else if (err_exp_q.size() > 0 && err_exp_q[0] < cyc) begin
        void'(err_exp_q.pop_front());
        check("err_missing", 64'(err), 64'd1);
      end

      if (!in_frame) begin
        if (done) check("done_idle", 64'(done), 64'd0);
        if (syn != all1) begin
          if (exp_q.size() == 0) begin
            check("frame_unexpected", 64'(syn), 64'(all1));
            cur = '0;
          end else begin
            cur = exp_q[0];
          end
          cur_syn = ~(NCH'(1) << cur.ch);
          check("frame_syn", 64'(syn), 64'(cur_syn));
          if (!cur.is_init) check("frame_start_cyc", 64'(cyc), 64'(cur.acc));
          if (have_end) check("syn_gap", 64'((cyc - last_end) >= 2), 64'd1);
          in_frame = 1'b1;
          nbits    = 0;
          got      = '0;
        end
      end else if (syn == all1) begin
        check("done_at_end", 64'(done), 64'(!cur.is_init));
        if (!cur.is_init) check("done_latency", 64'(cyc - int'(cur.acc) + 1), 64'(LAT));
        check("bit_count", 64'(nbits), 64'(DW));
        check("frame_data", 64'(got), 64'(cur.data));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        in_frame = 1'b0;
        last_end = cyc;
        have_end = 1'b1;
      end else begin
        if (syn != cur_syn) check("syn_stable", 64'(syn), 64'(cur_syn));
        if (done) check("done_mid_frame", 64'(done), 64'd0);
        if (prev_sclk && !sclk) begin
          check("din_stable_fall", 64'(din), 64'(prev_din));
          got = {got[DW-2:0], din};
          nbits++;
        end
      end
      prev_sclk = sclk;
      prev_din  = din;
    end
  end

  // stimulus
  initial begin
    int n;
    int k;
    exp_t e;
    reset = 1'b0;
    start = 1'b0;
    ch    = '0;
    data  = '0;
    repeat (3) @(negedge clk);
`ifdef SPI_DAC_WRITER_INIT_EN
    check("rst_ready", 64'(ready), 64'd0);
`else
    check("rst_ready", 64'(ready), 64'd1);
`endif
    check("rst_syn", 64'(syn), 64'(all1));
    check("rst_sclk", 64'(sclk), 64'd1);
    check("rst_din", 64'(din), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    reset = 1'b1;
    push_init();

    // directed corner words, then random channels (3 is out of range)
    issue(2'd1, 24'hA5F00F);
    issue(2'd3, 24'h123456);
    issue(2'd0, 24'hFFFFFF);
    issue(2'd2, 24'h000001);
    for (int i = 0; i < 22; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      issue(CW'($urandom_range(0, 3)), DW'($urandom));
    end

    // start held high: frames back to back
    if (!hung) begin
      wait_ready();
      start = 1'b1;
      k = 0;
      n = 0;
      while (k < 6 && n < 5000 && !hung) begin
        if (ready) begin
          ch   = CW'($urandom_range(0, NCH - 1));
          data = DW'($urandom);
          e = '{is_init: 1'b0, ch: ch, data: data, acc: 32'(cyc + 1)};
          exp_q.push_back(e);
          k++;
        end
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      if (k < 6) check("b2b_timeout", 64'(k), 64'd6);
    end

    // reset in the middle of a frame
    issue(2'd1, DW'($urandom));
    n = 0;
    while (!(in_frame && nbits >= 10) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reset_reach_bit10", 64'(nbits >= 10), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_syn", 64'(syn), 64'(all1));
    check("abort_sclk", 64'(sclk), 64'd1);
    check("abort_din", 64'(din), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push_init();
    issue(2'd2, 24'h5A5A5A);
    issue(2'd0, DW'($urandom));

    // drain
    n = 0;
    while ((exp_q.size() > 0 || err_exp_q.size() > 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_frames", 64'(exp_q.size()), 64'd0);
    check("drain_errs", 64'(err_exp_q.size()), 64'd0);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
